// File: rtl/input_mem_pkg.sv
// Shared constants and word/address types for the input-activation buffer.
package input_mem_pkg;

  localparam int unsigned SYS_ROW    = 16;
  localparam int unsigned SYS_COL    = 16;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : input_mem_pkg

// File: rtl/input_mem_bank.sv
// One activation bank: synchronous write port, registered read port whose
// output returns to zero on any cycle without a read.
module input_mem_bank #(
  parameter int unsigned DATA_WIDTH = input_mem_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = input_mem_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  import input_mem_pkg::*;

  localparam int unsigned BANK_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read data, zero when idle or in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule : input_mem_bank

// File: rtl/input_mem_unit.sv
// Input-activation buffer: fills SYS_ROW banks one vector per cycle, then
// replays the tile with a diagonal skew (bank j lags bank 0 by j cycles).
module input_mem_unit #(
  parameter int unsigned SYS_ROW    = input_mem_pkg::SYS_ROW,
  parameter int unsigned SYS_COL    = input_mem_pkg::SYS_COL,
  parameter int unsigned DATA_WIDTH = input_mem_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = input_mem_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_in,
  input  logic                  rd_en_in,
  input  logic [31:0]           num_row,
  input  logic [DATA_WIDTH-1:0] wr_data [SYS_ROW],
  output logic [DATA_WIDTH-1:0] rd_data [SYS_ROW],
  output logic                  wr_done,
  output logic                  rd_done
);

  import input_mem_pkg::*;

  localparam int unsigned UNIT_DEPTH = 1 << ADDR_WIDTH;
  // Pointer/row count must hold the full depth value itself.
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  // Read counter spans nrow + SYS_ROW - 1; the extra bit also keeps the
  // wrapped (rd_cnt - j) of not-yet-started banks above any valid row count.
  localparam int unsigned CNT_W = ADDR_WIDTH + 2;

  // Column count only shapes the downstream array; nothing here depends on it.
  if (SYS_COL == 0) begin : g_sys_col_reserved
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] nrow_q, nrow_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             started_q, started_d;
  logic             wr_done_q, wr_done_d;
  logic             rd_done_q, rd_done_d;

  logic [PTR_W-1:0] nrow_in_c;
  logic [PTR_W-1:0] nrow_eff_c;
  logic [PTR_W-1:0] wr_ptr_inc_c;
  logic [CNT_W-1:0] rd_last_c;
  logic             wr_acc_c;
  logic             wr_fire_c;
  logic             rd_step_c;

  // Row count clamped to bank depth; the live tile keeps its latched value.
  assign nrow_in_c    = (num_row > 32'(UNIT_DEPTH)) ? PTR_W'(UNIT_DEPTH) : PTR_W'(num_row);
  assign nrow_eff_c   = started_q ? nrow_q : nrow_in_c;
  assign wr_ptr_inc_c = wr_ptr_q + PTR_W'(1);
  assign rd_last_c    = CNT_W'(nrow_q) + CNT_W'(SYS_ROW) - CNT_W'(2);

  assign wr_acc_c  = wr_en_in && !wr_done_q;
  assign wr_fire_c = wr_acc_c && (nrow_eff_c != '0);
  assign rd_step_c = rd_en_in && wr_done_q;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      nrow_q    <= '0;
      rd_cnt_q  <= '0;
      started_q <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      nrow_q    <= nrow_d;
      rd_cnt_q  <= rd_cnt_d;
      started_q <= started_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
    end
  end

  // Next-state: write pointer advance, skewed read count, tile turnaround.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    nrow_d    = nrow_q;
    rd_cnt_d  = rd_cnt_q;
    started_d = started_q;
    wr_done_d = wr_done_q;
    rd_done_d = 1'b0;

    if (wr_acc_c) begin
      started_d = 1'b1;
      nrow_d    = nrow_eff_c;
      if (nrow_eff_c == '0) begin
        wr_done_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_inc_c;
        if (wr_ptr_inc_c == nrow_eff_c) begin
          wr_done_d = 1'b1;
        end
      end
    end

    if (rd_step_c) begin
      if (rd_cnt_q == rd_last_c) begin
        rd_done_d = 1'b1;
        wr_done_d = 1'b0;
        started_d = 1'b0;
        wr_ptr_d  = '0;
        rd_cnt_d  = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
    end
  end

  // Bank array; bank j reads row (rd_cnt - j) while that row exists.
  for (genvar j = 0; j < SYS_ROW; j++) begin : g_bank
    localparam logic [CNT_W-1:0] BANK_LAG = CNT_W'(j);

    logic [CNT_W-1:0] rel_row_c;
    logic             rd_hit_c;

    assign rel_row_c = rd_cnt_q - BANK_LAG;
    assign rd_hit_c  = rd_step_c && (rel_row_c < CNT_W'(nrow_q));

    input_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire_c),
      .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data (wr_data[j]),
      .rd_en   (rd_hit_c),
      .rd_addr (rel_row_c[ADDR_WIDTH-1:0]),
      .rd_data (rd_data[j])
    );
  end

  assign wr_done = wr_done_q;
  assign rd_done = rd_done_q;

endmodule : input_mem_unit

// File: tb/tb_input_mem_unit.sv
// Directed bench for input_mem_unit: fill, skewed replay, pauses, ignored
// requests, depth boundary, back-to-back tiles and reset abort.
module tb_input_mem_unit;

  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_in;
  logic        rd_en_in;
  logic [31:0] num_row;
  logic [15:0] wr_data [NB];
  logic [15:0] rd_data [NB];
  logic        wr_done;
  logic        rd_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  input_mem_unit dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en_in (wr_en_in),
    .rd_en_in (rd_en_in),
    .num_row  (num_row),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .wr_done  (wr_done),
    .rd_done  (rd_done)
  );

  // Advance one clock and settle past the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Row i carries 16*i + j in bank j.
  task automatic set_row(input int i);
    for (int j = 0; j < NB; j++) wr_data[j] = 16'(16 * i + j);
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int j = 0; j < NB; j++) wr_data[j] = v;
  endtask

  // Plain fill of n rows, no checking.
  task automatic fill_rows(input int n);
    num_row = 32'(n);
    rd_en_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_row(i);
      wr_en_in = 1'b1;
      cycle();
    end
    wr_en_in = 1'b0;
  endtask

  // Expected bank j output after read step with counter t for an n-row tile.
  function automatic logic [15:0] exp_skew(input int t, input int j, input int n);
    if (t >= j && (t - j) < n) return 16'(16 * (t - j) + j);
    return 16'h0000;
  endfunction

  task automatic test_reset();
    rst = 1'b1; wr_en_in = 1'b0; rd_en_in = 1'b0; num_row = 32'd0; set_all(16'h0);
    cycle(); cycle();
    rst = 1'b0;
    tests++;
    if (wr_done !== 1'b0) begin fails++; $display("FAIL reset_wr_done got=%b exp=0", wr_done); end
    tests++;
    if (rd_done !== 1'b0) begin fails++; $display("FAIL reset_rd_done got=%b exp=0", rd_done); end
    for (int j = 0; j < NB; j++) begin
      tests++;
      if (rd_data[j] !== 16'h0) begin fails++; $display("FAIL reset_rd_data bank=%0d got=%h exp=0000", j, rd_data[j]); end
    end
  endtask

  task automatic test_basic();
    num_row = 32'd8;
    for (int i = 0; i < 8; i++) begin
      set_row(i); wr_en_in = 1'b1;
      cycle();
      tests++;
      if (wr_done !== (i == 7)) begin fails++; $display("FAIL basic_wr_done write=%0d got=%b exp=%b", i, wr_done, i == 7); end
    end
    wr_en_in = 1'b0; rd_en_in = 1'b1;
    for (int s = 0; s < 23; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== exp_skew(s, j, 8)) begin
          fails++; $display("FAIL basic_rd_data step=%0d bank=%0d got=%h exp=%h", s + 1, j, rd_data[j], exp_skew(s, j, 8));
        end
      end
      tests++;
      if (rd_done !== (s == 22)) begin fails++; $display("FAIL basic_rd_done step=%0d got=%b exp=%b", s + 1, rd_done, s == 22); end
    end
    tests++;
    if (wr_done !== 1'b0) begin fails++; $display("FAIL basic_wr_done_clear got=%b exp=0", wr_done); end
    rd_en_in = 1'b0;
    cycle();
    tests++;
    if (rd_done !== 1'b0 || rd_data[15] !== 16'h0) begin
      fails++; $display("FAIL basic_after_done rd_done=%b rd15=%h exp=0/0000", rd_done, rd_data[15]);
    end
  endtask

  task automatic test_paused_write();
    num_row = 32'd8;
    for (int c = 0; c < 11; c++) begin
      if (c < 4) begin set_row(c); wr_en_in = 1'b1; end
      else if (c < 7) begin set_all(16'h5555); wr_en_in = 1'b0; end
      else begin set_row(c - 3); wr_en_in = 1'b1; end
      cycle();
      tests++;
      if (wr_done !== (c == 10)) begin fails++; $display("FAIL pwrite_wr_done cycle=%0d got=%b exp=%b", c, wr_done, c == 10); end
    end
    wr_en_in = 1'b0; rd_en_in = 1'b1;
    for (int s = 0; s < 23; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== exp_skew(s, j, 8)) begin
          fails++; $display("FAIL pwrite_rd_data step=%0d bank=%0d got=%h exp=%h", s + 1, j, rd_data[j], exp_skew(s, j, 8));
        end
      end
    end
    tests++;
    if (rd_done !== 1'b1) begin fails++; $display("FAIL pwrite_rd_done got=%b exp=1", rd_done); end
    rd_en_in = 1'b0;
  endtask

  task automatic test_paused_read();
    fill_rows(8);
    tests++;
    if (wr_done !== 1'b1) begin fails++; $display("FAIL pread_wr_done got=%b exp=1", wr_done); end
    rd_en_in = 1'b1;
    for (int s = 0; s < 10; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== exp_skew(s, j, 8)) begin
          fails++; $display("FAIL pread_pre_data step=%0d bank=%0d got=%h exp=%h", s + 1, j, rd_data[j], exp_skew(s, j, 8));
        end
      end
    end
    rd_en_in = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== 16'h0) begin fails++; $display("FAIL pread_gap_data gap=%0d bank=%0d got=%h exp=0000", p, j, rd_data[j]); end
      end
      tests++;
      if (rd_done !== 1'b0) begin fails++; $display("FAIL pread_gap_done gap=%0d got=%b exp=0", p, rd_done); end
    end
    rd_en_in = 1'b1;
    for (int s = 10; s < 23; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== exp_skew(s, j, 8)) begin
          fails++; $display("FAIL pread_post_data step=%0d bank=%0d got=%h exp=%h", s + 1, j, rd_data[j], exp_skew(s, j, 8));
        end
      end
      tests++;
      if (rd_done !== (s == 22)) begin fails++; $display("FAIL pread_rd_done step=%0d got=%b exp=%b", s + 1, rd_done, s == 22); end
    end
    rd_en_in = 1'b0;
  endtask

  task automatic test_ignored();
    wr_en_in = 1'b0; rd_en_in = 1'b1; num_row = 32'd8;
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests++;
      if (rd_data[0] !== 16'h0 || wr_done !== 1'b0) begin
        fails++; $display("FAIL ign_early_read cycle=%0d rd0=%h wr_done=%b exp=0000/0", c, rd_data[0], wr_done);
      end
    end
    fill_rows(8);
    set_all(16'hFFFF); wr_en_in = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      tests++;
      if (wr_done !== 1'b1 || rd_data[0] !== 16'h0) begin
        fails++; $display("FAIL ign_extra_write cycle=%0d wr_done=%b rd0=%h exp=1/0000", c, wr_done, rd_data[0]);
      end
    end
    wr_en_in = 1'b0; rd_en_in = 1'b1;
    for (int s = 0; s < 23; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== exp_skew(s, j, 8)) begin
          fails++; $display("FAIL ign_rd_data step=%0d bank=%0d got=%h exp=%h", s + 1, j, rd_data[j], exp_skew(s, j, 8));
        end
      end
    end
    tests++;
    if (rd_done !== 1'b1) begin fails++; $display("FAIL ign_rd_done got=%b exp=1", rd_done); end
    rd_en_in = 1'b0;
  endtask

  // num_row above depth clamps to 256; bank 15 reaches address 255 on step 271.
  task automatic test_full_depth();
    num_row = 32'd300;
    for (int i = 0; i < 256; i++) begin
      set_row(i); wr_en_in = 1'b1;
      cycle();
      tests++;
      if (wr_done !== (i == 255)) begin fails++; $display("FAIL depth_wr_done write=%0d got=%b exp=%b", i, wr_done, i == 255); end
    end
    wr_en_in = 1'b0; rd_en_in = 1'b1;
    for (int s = 0; s < 271; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== exp_skew(s, j, 256)) begin
          fails++; $display("FAIL depth_rd_data step=%0d bank=%0d got=%h exp=%h", s + 1, j, rd_data[j], exp_skew(s, j, 256));
        end
      end
      tests++;
      if (rd_done !== (s == 270)) begin fails++; $display("FAIL depth_rd_done step=%0d got=%b exp=%b", s + 1, rd_done, s == 270); end
    end
    tests++;
    if (rd_data[15] !== 16'h0FFF) begin fails++; $display("FAIL depth_last_bank15 got=%h exp=0fff", rd_data[15]); end
  endtask

  // Starts in the same cycle rd_done of the previous tile is visible.
  task automatic test_back_to_back();
    rd_en_in = 1'b0; num_row = 32'd1; set_all(16'hABCD); wr_en_in = 1'b1;
    cycle();
    tests++;
    if (wr_done !== 1'b1 || rd_done !== 1'b0) begin
      fails++; $display("FAIL b2b_wr_done wr_done=%b rd_done=%b exp=1/0", wr_done, rd_done);
    end
    wr_en_in = 1'b0; rd_en_in = 1'b1;
    for (int s = 0; s < 16; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== ((j == s) ? 16'hABCD : 16'h0)) begin
          fails++; $display("FAIL b2b_rd_data step=%0d bank=%0d got=%h exp=%h", s + 1, j, rd_data[j], (j == s) ? 16'hABCD : 16'h0);
        end
      end
      tests++;
      if (rd_done !== (s == 15)) begin fails++; $display("FAIL b2b_rd_done step=%0d got=%b exp=%b", s + 1, rd_done, s == 15); end
    end
    rd_en_in = 1'b0;
  endtask

  // Zero-row tile: done after one request, then 15 all-zero steps.
  task automatic test_zero_rows();
    num_row = 32'd0; set_all(16'h1234); wr_en_in = 1'b1;
    cycle();
    tests++;
    if (wr_done !== 1'b1) begin fails++; $display("FAIL zero_wr_done got=%b exp=1", wr_done); end
    wr_en_in = 1'b0; rd_en_in = 1'b1;
    for (int s = 0; s < 15; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== 16'h0) begin fails++; $display("FAIL zero_rd_data step=%0d bank=%0d got=%h exp=0000", s + 1, j, rd_data[j]); end
      end
      tests++;
      if (rd_done !== (s == 14)) begin fails++; $display("FAIL zero_rd_done step=%0d got=%b exp=%b", s + 1, rd_done, s == 14); end
    end
    rd_en_in = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    fill_rows(8);
    rd_en_in = 1'b1;
    for (int s = 0; s < 5; s++) cycle();
    tests++;
    if (rd_data[0] !== 16'd64) begin fails++; $display("FAIL rmid_pre_data got=%h exp=0040", rd_data[0]); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int j = 0; j < NB; j++) begin
      tests++;
      if (rd_data[j] !== 16'h0) begin fails++; $display("FAIL rmid_rd_data bank=%0d got=%h exp=0000", j, rd_data[j]); end
    end
    tests++;
    if (wr_done !== 1'b0 || rd_done !== 1'b0) begin
      fails++; $display("FAIL rmid_flags wr_done=%b rd_done=%b exp=0/0", wr_done, rd_done);
    end
    cycle();
    tests++;
    if (rd_data[0] !== 16'h0) begin fails++; $display("FAIL rmid_ignored_read got=%h exp=0000", rd_data[0]); end
    fill_rows(2);
    tests++;
    if (wr_done !== 1'b1) begin fails++; $display("FAIL rmid_refill_done got=%b exp=1", wr_done); end
    rd_en_in = 1'b1;
    for (int s = 0; s < 17; s++) begin
      cycle();
      for (int j = 0; j < NB; j++) begin
        tests++;
        if (rd_data[j] !== exp_skew(s, j, 2)) begin
          fails++; $display("FAIL rmid_refill_data step=%0d bank=%0d got=%h exp=%h", s + 1, j, rd_data[j], exp_skew(s, j, 2));
        end
      end
      tests++;
      if (rd_done !== (s == 16)) begin fails++; $display("FAIL rmid_refill_done step=%0d got=%b exp=%b", s + 1, rd_done, s == 16); end
    end
    rd_en_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en_in = 1'b0; rd_en_in = 1'b0; num_row = 32'd0;
    for (int j = 0; j < NB; j++) wr_data[j] = 16'h0;
    #1;
    test_reset();
    test_basic();
    test_paused_write();
    test_paused_read();
    test_ignored();
    test_full_depth();
    test_back_to_back();
    test_zero_rows();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_input_mem_unit
